// File: rtl/demuxtwo_tdm_if.sv
// demuxtwo_tdm_if: serial TDM input and the two recovered parallel channels
interface demuxtwo_tdm_if #(parameter int WIDTH = 8);
   logic             din;
   logic             sync;
   logic [WIDTH-1:0] a_word;
   logic             a_valid;
   logic [WIDTH-1:0] b_word;
   logic             b_valid;
   logic             locked;
   logic             sync_err;
   modport master (output din, sync, input a_word, a_valid, b_word, b_valid, locked, sync_err);
   modport slave  (input din, sync, output a_word, a_valid, b_word, b_valid, locked, sync_err);
endinterface

// File: rtl/demuxtwo_tdm.sv
// demuxtwo_tdm: frame-locked deserializer splitting a 1-bit TDM stream into channels a and b
module demuxtwo_tdm #(
   parameter int WIDTH = 8
) (
   input logic           clock,
   input logic           reset,
   demuxtwo_tdm_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {HUNT, RX_A, RX_B} state_t;
   state_t         state;
   logic [CW-1:0]  cnt;
   logic [WIDTH-2:0] shift;
   logic           last;
   logic           frame_start;
   assign last        = cnt == CW'(WIDTH - 1);
   assign frame_start = state == RX_A && cnt == '0;
   // framing FSM: hunt for sync, then alternate a/b slots, checking sync only at frame start
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= HUNT;
         cnt          <= '0;
         shift        <= '0;
         bus.a_word   <= '0;
         bus.b_word   <= '0;
         bus.a_valid  <= 1'b0;
         bus.b_valid  <= 1'b0;
         bus.locked   <= 1'b0;
         bus.sync_err <= 1'b0;
      end else begin
         bus.a_valid  <= 1'b0;
         bus.b_valid  <= 1'b0;
         bus.sync_err <= 1'b0;
         if (state == HUNT) begin
            if (bus.sync) begin
               shift      <= (WIDTH-1)'(bus.din);
               cnt        <= CW'(1);
               state      <= RX_A;
               bus.locked <= 1'b1;
            end
         end else if (frame_start && !bus.sync) begin
            bus.sync_err <= 1'b1;
            cnt          <= '0;
            shift        <= '0;
            state        <= HUNT;
            bus.locked   <= 1'b0;
         end else if (bus.sync && !frame_start) begin
            bus.sync_err <= 1'b1;
            shift        <= (WIDTH-1)'(bus.din);
            cnt          <= CW'(1);
            state        <= RX_A;
         end else begin
            shift <= (WIDTH-1)'({shift, bus.din});
            cnt   <= last ? '0 : cnt + CW'(1);
            if (last && state == RX_A) begin
               bus.a_word  <= {shift, bus.din};
               bus.a_valid <= 1'b1;
               state       <= RX_B;
            end else if (last) begin
               bus.b_word  <= {shift, bus.din};
               bus.b_valid <= 1'b1;
               state       <= RX_A;
            end
         end
      end
   end
endmodule

// File: doc/demuxtwo_tdm.md
Name: demuxtwo_tdm

Overview:
Receive-side counterpart of the two-input mux path. Takes a 1-bit time-division-multiplexed serial stream that carries alternating channel-a and channel-b slots, locks onto a frame sync marker, and deserializes each slot into a parallel word on the matching output channel. Sits downstream of the mux/serializer path and restores the two original streams, each with its own per-word valid strobe.

Parameters:
WIDTH, 8, bits per slot word; legal range is WIDTH >= 2.

Ports:
clock    input   1      system clock; all logic is on the rising edge
reset    input   1      synchronous, active-high reset
din      input   1      serial TDM data, MSB first, one bit per clock
sync     input   1      high on the first bit (a-slot MSB) of every frame
a_word   output  WIDTH  last completed channel-a word
a_valid  output  1      one-cycle strobe: a_word was updated this cycle
b_word   output  WIDTH  last completed channel-b word
b_valid  output  1      one-cycle strobe: b_word was updated this cycle
locked   output  1      high while the receiver is framed (state != HUNT)
sync_err output  1      one-cycle strobe: framing violation detected

Behaviour:
- Frame format: WIDTH bits of channel a, then WIDTH bits of channel b, all MSB first. Frame length is 2*WIDTH clocks.
- All outputs are registered. The clock and reset are synchronous and active-high, as decided.
- Reset (any cycle, including mid-word): state = HUNT, bit counter = 0, shift register = 0, a_word = 0, b_word = 0. Also a_valid = 0, b_valid = 0, locked = 0, sync_err = 0. Any partial word is discarded.
- Bit counter width is $clog2(WIDTH). It counts 0..WIDTH-1 within a slot and wraps to 0 at slot end.
- States and transitions:
  - HUNT:
    - sync = 0: din is ignored.
    - sync = 1: din is shifted in as bit 0 of slot a; counter = 1; go to RX_A.
  - RX_A: shift din in each cycle. On the cycle the counter is WIDTH-1:
    - a_word <= {shift[WIDTH-2:0], din};
    - a_valid = 1 for the following cycle only;
    - counter = 0; go to RX_B.
  - RX_B: same as RX_A, but loads b_word and pulses b_valid. At slot end go to RX_A with frame_start expected.
- Sync checking:
  - sync must be 1 exactly on bit 0 of RX_A (the frame start).
  - Missing sync at the expected frame start: sync_err pulses, the bit is discarded, state goes to HUNT, locked drops next cycle.
  - Sync asserted at any other bit position while in RX_A or RX_B: sync_err pulses and the partial word is discarded with no valid strobe. The receiver resyncs: this bit becomes bit 0 of slot a, counter = 1, state = RX_A, locked stays 1.
- Latency: a_valid or b_valid is high in the cycle after the clock edge that samples the slot's last bit.
- a_valid and b_valid are never high in the same cycle.
- a_word and b_word hold their value between updates.
- The first frame after HUNT is fully captured; its sync bit is bit 0 of that frame.

Test Plan:
- Reset then lock, WIDTH=8: assert reset for 2 cycles, then send a frame a=0xA5, b=0x3C with sync on the first bit. Required: locked=1 from the cycle after sync, a_valid one cycle after bit 7 with a_word=0xA5, b_valid 8 cycles later with b_word=0x3C, sync_err=0 throughout.
- Back-to-back frames: send 4 frames (0x01/0x80, 0xFF/0x00, 0x5A/0xC3, 0x7E/0x81) with correct sync. Required: 8 alternating strobes at 8-cycle spacing, correct words, no sync_err.
- Missing sync: omit sync at the start of frame 2. Required: sync_err pulses once, locked=0 the next cycle, no a_valid for frame 2, relock on the next sync.
- Early sync: assert sync at bit 3 of an a-slot. Required: sync_err pulses, no a_valid for the broken word, locked stays 1, a fresh frame 0x99/0x66 starting at that bit is captured correctly.
- Mid-word reset: assert reset at bit 5 of a b-slot. Required: next cycle all outputs are 0, state is HUNT, and no b_valid appears for the discarded word.
- Parameter sweep at WIDTH=2 and WIDTH=16: frame 0b10/0b01 and frame 0xBEEF/0x1234 are each captured with strobe spacing equal to WIDTH.
